// File: rtl/fp_bcd2bin_seq.sv
// Sequential fixed-point BCD (6.6 digits) to binary (40-bit, FRAC_BITS fraction) converter.
// Doubles the BCD operand FRAC_BITS times, rounds half-up, then Horner-evaluates the 13 integer digits.
module fp_bcd2bin_seq #(
  parameter int FRAC_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] fp_bcd,
  output logic        busy,
  output logic        done,
  output logic [39:0] fp_bin
);

  typedef enum logic [1:0] {IDLE, DBL, RND, CONV} state_t;

  localparam logic [4:0] LAST_DBL = 5'(FRAC_BITS - 1);

  state_t      state_q;
  logic [75:0] acc_q;
  logic [51:0] rbcd_q;
  logic [43:0] bin_q;
  logic [4:0]  cnt_q;
  logic [3:0]  idx_q;
  logic        busy_q;
  logic        done_q;
  logic [39:0] fp_bin_q;

  logic [75:0] acc_d;
  logic [51:0] rbcd_d;
  logic [43:0] bin_d;
  logic [12:0] inc_c;
  logic [3:0]  rdig [16];
  logic [3:0]  cur_dig;

  // Each doubled digit is 2d mod 10 plus a carry that is simply (lower digit >= 5).
  generate
    for (genvar gi = 0; gi < 19; gi++) begin : g_dbl
      logic [3:0] dig;
      logic [3:0] lo;
      assign dig = acc_q[4*gi +: 4];
      assign lo  = (dig >= 4'd5) ? ({dig[2:0], 1'b0} + 4'd6) : {dig[2:0], 1'b0};
      if (gi == 0) begin : g_lsd
        assign acc_d[3:0] = lo;
      end else begin : g_up
        assign acc_d[4*gi +: 4] = lo | {3'b000, (acc_q[4*(gi-1) +: 4] >= 4'd5)};
      end
    end
  endgenerate

  // Rounding increment ripples through trailing nines of the 13 integer digits.
  assign inc_c[0] = (acc_q[23:20] >= 4'd5);
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_inc
      logic [3:0] dig;
      assign dig = acc_q[24 + 4*gi +: 4];
      assign rbcd_d[4*gi +: 4] = inc_c[gi] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      if (gi < 12) begin : g_carry
        assign inc_c[gi+1] = inc_c[gi] & (dig == 4'd9);
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sel
      if (gi < 13) begin : g_dig
        assign rdig[gi] = rbcd_q[4*gi +: 4];
      end else begin : g_pad
        assign rdig[gi] = 4'd0;
      end
    end
  endgenerate

  assign cur_dig = rdig[idx_q];
  assign bin_d   = (bin_q << 3) + (bin_q << 1) + {40'd0, cur_dig};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rbcd_q   <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fp_bin_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= {28'd0, fp_bcd};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DBL;
          end
        end
        DBL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_DBL) begin
            state_q <= RND;
          end
        end
        RND: begin
          rbcd_q  <= rbcd_d;
          bin_q   <= '0;
          idx_q   <= 4'd12;
          state_q <= CONV;
        end
        CONV: begin
          bin_q <= bin_d;
          idx_q <= idx_q - 4'd1;
          if (idx_q == 4'd0) begin
            fp_bin_q <= bin_d[39:0];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign fp_bin = fp_bin_q;

endmodule

// File: tb/tb_fp_bcd2bin_seq.sv
// Randomized and directed bench for fp_bcd2bin_seq against an arithmetic reference model.
module tb_fp_bcd2bin_seq;

  localparam int FRAC_BITS = 20;
  localparam int LAT       = FRAC_BITS + 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [47:0] fp_bcd;
  logic        busy;
  logic        done;
  logic [39:0] fp_bin;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_bcd2bin_seq #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .fp_bcd (fp_bcd),
    .busy   (busy),
    .done   (done),
    .fp_bin (fp_bin)
  );

  // round(value * 2^FRAC_BITS) with value = digits / 10^6, half-up
  function automatic logic [39:0] ref_conv(input logic [47:0] op);
    longint unsigned v;
    v = 0;
    for (int i = 11; i >= 0; i--) v = v * 10 + 64'(op[4*i +: 4]);
    v = (v * (64'd1 << FRAC_BITS) + 64'd500000) / 64'd1000000;
    return v[39:0];
  endfunction

  function automatic logic [47:0] rand_bcd();
    logic [47:0] r;
    for (int i = 0; i < 12; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted request and reports latency, result and busy anomalies.
  task automatic do_conv(input logic [47:0] op, output int lat, output logic [39:0] res,
                         output int busy_bad);
    start  = 1'b1;
    fp_bcd = op;
    tick();
    start    = 1'b0;
    fp_bcd   = rand_bcd();
    lat      = -1;
    res      = '0;
    busy_bad = 0;
    for (int n = 1; n <= LAT + 20; n++) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      if (done === 1'b1) begin
        lat = n;
        res = fp_bin;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
    end
    $display("conv op=%h res=%h latency=%0d", op, res, lat);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    fp_bcd = '0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (fp_bin !== 40'd0) begin n_fail++; $display("FAIL reset_fp_bin got %h want 0", fp_bin); end
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [47:0] ops [7] = '{48'h000000_500000, 48'h000000_000000, 48'h000000_000001,
                             48'h000000_000100, 48'h000000_000010, 48'h999999_999999,
                             48'h000001_000000};
    logic [39:0] exps [7] = '{40'h00_0008_0000, 40'h0, 40'h1, 40'h69, 40'h0A,
                              40'hF4_23FF_FFFF, 40'h00_0010_0000};
    int lat, bb;
    logic [39:0] res;
    for (int i = 0; i < 7; i++) begin
      do_conv(ops[i], lat, res, bb);
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, LAT); end
      n_checks++; if (res !== exps[i]) begin n_fail++; $display("FAIL dir_result[%0d] got %h want %h", i, res, exps[i]); end
      n_checks++; if (bb != 0) begin n_fail++; $display("FAIL dir_busy[%0d] got %0d bad cycles want 0", i, bb); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse[%0d] got %b want 0", i, done); end
      n_checks++; if (fp_bin !== exps[i]) begin n_fail++; $display("FAIL dir_hold[%0d] got %h want %h", i, fp_bin, exps[i]); end
    end
  endtask

  task automatic test_abort();
    int lat, bb, spurious;
    logic [39:0] res;
    start  = 1'b1;
    fp_bcd = rand_bcd();
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
    n_checks++; if (fp_bin !== 40'd0) begin n_fail++; $display("FAIL abort_fp_bin got %h want 0", fp_bin); end
    tick();
    tick();
    reset    = 1'b0;
    spurious = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      if (done !== 1'b0) spurious++;
    end
    n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", spurious); end
    do_conv(48'h000001_000000, lat, res, bb);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL abort_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (res !== 40'h00_0010_0000) begin n_fail++; $display("FAIL abort_result got %h want 0000100000", res); end
  endtask

  task automatic test_random();
    int lat, bb;
    logic [39:0] res, exp_res;
    logic [47:0] op;
    for (int i = 0; i < 20; i++) begin
      op      = rand_bcd();
      exp_res = ref_conv(op);
      do_conv(op, lat, res, bb);
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd_latency[%0d] got %0d want %0d", i, lat, LAT); end
      n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL rnd_result[%0d] op=%h got %h want %h", i, op, res, exp_res); end
      n_checks++; if (bb != 0) begin n_fail++; $display("FAIL rnd_busy[%0d] got %0d bad cycles want 0", i, bb); end
    end
  endtask

  // start held high, operand changes every cycle; the DUT is idle (done cycle) on entry
  task automatic test_back_to_back();
    bit          m_idle = 1'b1;
    int          m_cnt = 0;
    logic [47:0] m_op = '0;
    logic [47:0] op;
    logic        exp_done;
    logic [39:0] exp_res = '0;
    int          dut_dones = 0, model_dones = 0;
    for (int k = 0; k < 4 * (LAT + 1) + 3; k++) begin
      op     = rand_bcd();
      start  = 1'b1;
      fp_bcd = op;
      @(posedge clk);
      exp_done = 1'b0;
      if (m_idle) begin
        m_op   = op;
        m_cnt  = LAT;
        m_idle = 1'b0;
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          exp_done = 1'b1;
          m_idle   = 1'b1;
          exp_res  = ref_conv(m_op);
          model_dones++;
        end
      end
      #1;
      if (done === 1'b1) dut_dones++;
      n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL b2b_done[%0d] got %b want %b", k, done, exp_done); end
      if (exp_done) begin
        $display("b2b op=%h res=%h", m_op, fp_bin);
        n_checks++; if (fp_bin !== exp_res) begin n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", k, fp_bin, exp_res); end
      end
    end
    n_checks++; if (dut_dones != model_dones) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", dut_dones, model_dones); end
    start = 1'b0;
    for (int k = 0; k < LAT + 2; k++) tick();
  endtask

  task automatic test_ignore_busy();
    logic [47:0] op_a, op_b;
    logic [39:0] exp_res;
    int n, extra;
    op_a = rand_bcd();
    op_b = rand_bcd();
    if (op_b == op_a) op_b = op_a ^ 48'h000000_000001;
    exp_res = ref_conv(op_a);
    start  = 1'b1;
    fp_bcd = op_a;
    tick();
    start  = 1'b0;
    fp_bcd = rand_bcd();
    for (int k = 0; k < 5; k++) tick();
    start  = 1'b1;
    fp_bcd = op_b;
    tick();
    start  = 1'b0;
    fp_bcd = rand_bcd();
    n = 6;
    for (int k = 0; k < LAT + 20; k++) begin
      tick();
      n++;
      if (done === 1'b1) break;
    end
    $display("busy_start op=%h ignored=%h res=%h latency=%0d", op_a, op_b, fp_bin, n);
    n_checks++; if (done !== 1'b1 || n != LAT) begin n_fail++; $display("FAIL ign_latency got done=%b at %0d want 1 at %0d", done, n, LAT); end
    n_checks++; if (fp_bin !== exp_res) begin n_fail++; $display("FAIL ign_result got %h want %h", fp_bin, exp_res); end
    extra = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL ign_no_extra got %0d active cycles want 0", extra); end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    fp_bcd = '0;
    test_reset();
    test_directed();
    test_abort();
    test_random();
    test_back_to_back();
    test_ignore_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule
